// File: rtl/param_sync_memory.sv
// DATA_W x 2**ADDR_W synchronous register-file memory with registered read port,
// post-reset clear sequencer and tri-state dout. Optional macro: PARITY_EN (per-word even parity).
module param_sync_memory #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              rd,
  input  logic              oe,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              parity_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  // FSM state kept as a plain named signal so checkers can bind to it directly.
  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata;
  logic              wr_en;
  logic              rd_en;

  // Bus access: a transfer happens on an edge where cs=1 and the block is idle;
  // rd selects read (data in rdata next cycle, flagged by dout_valid) or write.
  assign wr_en = (state == IDLE) && cs && !rd;
  assign rd_en = (state == IDLE) && cs && rd;
  assign busy  = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clr_ptr    <= '0;
      rdata      <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_en;
      if (rd_en) rdata <= mem[addr];
      if (state == CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
        if (clr_ptr == ADDR_W'(DEPTH - 1)) state <= IDLE;
      end
    end
  end

  // Array has no reset of its own; the clear sequence zeroes it word by word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[clr_ptr] <= '0;
      else if (wr_en)     mem[addr]    <= din;
    end
  end

`ifdef PARITY_EN
  logic par [DEPTH];
  logic parity_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) par[clr_ptr] <= 1'b0;
      else if (wr_en)     par[addr]    <= ^din;
    end
  end

  // Registered with rdata so the flag lines up with dout_valid.
  always_ff @(posedge clk) begin
    if (rst)        parity_q <= 1'b0;
    else if (rd_en) parity_q <= (^mem[addr]) ^ par[addr];
  end

  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

  assign dout = oe ? rdata : {DATA_W{1'bz}};

endmodule
